// File: rtl/pipeline_pkg.sv
// Shared decode constants for the pipeline: field widths, opcodes, functs,
// ALU operation codes, immediate selection and the ID/EX control word layout.
package pipeline_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned OPC_W    = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned CTRL_W   = 12;
  localparam int unsigned REGS_W   = 3 * REG_AW;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0a;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2b;

  localparam logic [OPC_W-1:0] FN_SLL = 6'h00;
  localparam logic [OPC_W-1:0] FN_SRL = 6'h02;
  localparam logic [OPC_W-1:0] FN_JR  = 6'h08;
  localparam logic [OPC_W-1:0] FN_ADD = 6'h20;
  localparam logic [OPC_W-1:0] FN_SUB = 6'h22;
  localparam logic [OPC_W-1:0] FN_AND = 6'h24;
  localparam logic [OPC_W-1:0] FN_OR  = 6'h25;
  localparam logic [OPC_W-1:0] FN_SLT = 6'h2a;

  localparam logic [REG_AW-1:0] RA_REG = REG_AW'(31);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_LUI = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_SIGN  = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_SHAMT = 2'd2
  } imm_sel_e;

  // Field order fixes the control bit positions: reg_write is bit 11, alu_op is [3:0].
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    branch_ne;
    logic    link;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch register, writeback/MEM hazard inputs, fetch control
// and the ID/EX pipeline register outputs.
interface id_stage_if;
  import pipeline_pkg::*;

  logic [2*XLEN-1:0] IF_ID;
  logic              wb_RegWrite;
  logic [REG_AW-1:0] wb_dest;
  logic [XLEN-1:0]   wb_data;
  logic              exmem_RegWrite;
  logic [REG_AW-1:0] exmem_dest;
  logic              flush_ID_EX;

  logic              PC_IF_ID_Write;
  logic [1:0]        select_JJR;
  logic [XLEN-1:0]   jump_target;
  logic [XLEN-1:0]   jr_target;
  logic              illegal_inst;
  logic [XLEN-1:0]   ID_EX_PC_plus4;
  logic [XLEN-1:0]   ID_EX_rs_data;
  logic [XLEN-1:0]   ID_EX_rt_data;
  logic [XLEN-1:0]   ID_EX_imm;
  logic [REGS_W-1:0] ID_EX_regs;
  logic [CTRL_W-1:0] ID_EX_ctrl;

  modport master (
    output IF_ID, wb_RegWrite, wb_dest, wb_data, exmem_RegWrite, exmem_dest, flush_ID_EX,
    input  PC_IF_ID_Write, select_JJR, jump_target, jr_target, illegal_inst,
    input  ID_EX_PC_plus4, ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_regs, ID_EX_ctrl
  );

  modport slave (
    input  IF_ID, wb_RegWrite, wb_dest, wb_data, exmem_RegWrite, exmem_dest, flush_ID_EX,
    output PC_IF_ID_Write, select_JJR, jump_target, jr_target, illegal_inst,
    output ID_EX_PC_plus4, ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_regs, ID_EX_ctrl
  );

endinterface

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through from the
// single write port, $0 hardwired to zero, synchronous active-low clear.
module register_file
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_a,
  output logic [XLEN-1:0]   rdata_b
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle writes are forwarded so decode sees the value being written back.
  assign rdata_a = (raddr_a == '0)                ? '0    :
                   (we && waddr == raddr_a)       ? wdata : regs[raddr_a];
  assign rdata_b = (raddr_b == '0)                ? '0    :
                   (we && waddr == raddr_b)       ? wdata : regs[raddr_b];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decodes IF_ID, reads operands, detects load-use and
// jr hazards, steers fetch for j/jal/jr and loads the ID/EX pipeline register.
module id_stage
  import pipeline_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  id_stage_if.slave bus
);

  logic [XLEN-1:0]   instr;
  logic [XLEN-1:0]   pc_plus4;
  logic [OPC_W-1:0]  opcode;
  logic [OPC_W-1:0]  funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] shamt;
  logic [IMM_W-1:0]  imm16;

  assign {pc_plus4, instr} = bus.IF_ID;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];

  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;

  register_file u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.wb_RegWrite),
    .waddr   (bus.wb_dest),
    .wdata   (bus.wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  ctrl_t             dec_ctrl;
  logic [REG_AW-1:0] dec_dest;
  imm_sel_e          imm_sel;
  logic              dec_illegal;
  logic              dec_jump;
  logic              dec_jr;

  // Opcode/funct decode into the control word, destination and immediate kind.
  always_comb begin
    dec_ctrl    = '0;
    dec_dest    = rt;
    imm_sel     = IMM_SIGN;
    dec_illegal = 1'b0;
    dec_jump    = 1'b0;
    dec_jr      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_dest           = rd;
        dec_ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD: dec_ctrl.alu_op = ALU_ADD;
          FN_SUB: dec_ctrl.alu_op = ALU_SUB;
          FN_AND: dec_ctrl.alu_op = ALU_AND;
          FN_OR:  dec_ctrl.alu_op = ALU_OR;
          FN_SLT: dec_ctrl.alu_op = ALU_SLT;
          FN_SLL: begin
            dec_ctrl.alu_op = ALU_SLL;
            imm_sel         = IMM_SHAMT;
          end
          FN_SRL: begin
            dec_ctrl.alu_op = ALU_SRL;
            imm_sel         = IMM_SHAMT;
          end
          FN_JR: begin
            dec_ctrl.reg_write = 1'b0;
            dec_jr             = 1'b1;
          end
          default: begin
            dec_ctrl.reg_write = 1'b0;
            dec_illegal        = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        dec_ctrl.branch_ne = 1'b1;
        dec_ctrl.alu_op    = ALU_SUB;
      end
      OP_ADDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      OP_SLTI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_SLT;
      end
      OP_ANDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_AND;
        imm_sel            = IMM_ZERO;
      end
      OP_ORI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_OR;
        imm_sel            = IMM_ZERO;
      end
      OP_LUI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_LUI;
      end
      OP_J: dec_jump = 1'b1;
      OP_JAL: begin
        dec_jump           = 1'b1;
        dec_dest           = RA_REG;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.link      = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // The all-zero word is the pipeline NOP, not a write to $0.
    if (instr == '0) dec_ctrl = '0;
  end

  logic [XLEN-1:0] dec_imm;

  always_comb begin
    case (imm_sel)
      IMM_ZERO:  dec_imm = XLEN'(imm16);
      IMM_SHAMT: dec_imm = XLEN'(shamt);
      default:   dec_imm = {{(XLEN-IMM_W){imm16[IMM_W-1]}}, imm16};
    endcase
  end

  ctrl_t             idex_ctrl;
  logic [REG_AW-1:0] idex_dest;
  logic [REGS_W-1:0] idex_regs;
  logic              load_use;
  logic              jr_hazard;
  logic              stall;
  logic              issue;

  assign idex_dest = idex_regs[REG_AW-1:0];
  assign load_use  = idex_ctrl.mem_read && (idex_dest != '0) &&
                     (idex_dest == rs || idex_dest == rt);
  // jr resolves in ID, so it must wait until its source is past MEM.
  assign jr_hazard = dec_jr && (rs != '0) &&
                     ((idex_ctrl.reg_write && idex_dest == rs) ||
                      (bus.exmem_RegWrite && bus.exmem_dest == rs));
  assign stall     = load_use || jr_hazard;
  assign issue     = !bus.flush_ID_EX && !stall && !dec_illegal;

  assign bus.PC_IF_ID_Write = bus.flush_ID_EX || !stall;
  assign bus.select_JJR     = issue ? {dec_jump, dec_jr} : 2'b00;
  assign bus.illegal_inst   = dec_illegal && !bus.flush_ID_EX;
  assign bus.jump_target    = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign bus.jr_target      = rs_data;

  logic [XLEN-1:0] idex_pc_plus4;
  logic [XLEN-1:0] idex_rs_data;
  logic [XLEN-1:0] idex_rt_data;
  logic [XLEN-1:0] idex_imm;

  // Reset, stall, flush and illegal all load an all-zero bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || !issue) begin
      idex_pc_plus4 <= '0;
      idex_rs_data  <= '0;
      idex_rt_data  <= '0;
      idex_imm      <= '0;
      idex_regs     <= '0;
      idex_ctrl     <= '0;
    end else begin
      idex_pc_plus4 <= pc_plus4;
      idex_rs_data  <= rs_data;
      idex_rt_data  <= rt_data;
      idex_imm      <= dec_imm;
      idex_regs     <= {rs, rt, dec_dest};
      idex_ctrl     <= dec_ctrl;
    end
  end

  assign bus.ID_EX_PC_plus4 = idex_pc_plus4;
  assign bus.ID_EX_rs_data  = idex_rs_data;
  assign bus.ID_EX_rt_data  = idex_rt_data;
  assign bus.ID_EX_imm      = idex_imm;
  assign bus.ID_EX_regs     = idex_regs;
  assign bus.ID_EX_ctrl     = idex_ctrl;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed hazard/jump/illegal scenarios and a
// randomized instruction stream checked against a behavioural decode model.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  id_stage_if bus ();

  id_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        legal;
    logic [11:0] ctrl;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        is_j;
    logic        is_jr;
  } dec_t;

  logic [31:0] m_regs [32];
  int unsigned fn_tab [8] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2a, 32'h00, 32'h02, 32'h08};
  int unsigned op_tab [9] = '{32'h23, 32'h2b, 32'h04, 32'h05, 32'h08, 32'h0a, 32'h0c, 32'h0d, 32'h0f};
  int unsigned bad_op [4] = '{32'h3f, 32'h01, 32'h10, 32'h22};

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Reference decode: per-mnemonic flags combined arithmetically into the control word.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    int rw = 0, mr = 0, mw = 0, m2r = 0, asrc = 0, br = 0, bn = 0, lnk = 0, alu = 0, immk = 0;
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    d = '0;
    d.legal = 1'b1;
    d.dest = ins[20:16];
    case (op)
      0: begin
        d.dest = ins[15:11];
        case (fn)
          'h20: rw = 1;
          'h22: begin rw = 1; alu = 1; end
          'h24: begin rw = 1; alu = 2; end
          'h25: begin rw = 1; alu = 3; end
          'h2a: begin rw = 1; alu = 4; end
          'h00: begin rw = 1; alu = 5; immk = 2; end
          'h02: begin rw = 1; alu = 6; immk = 2; end
          'h08: d.is_jr = 1'b1;
          default: d.legal = 1'b0;
        endcase
      end
      'h23: begin rw = 1; mr = 1; m2r = 1; asrc = 1; end
      'h2b: begin mw = 1; asrc = 1; end
      'h04: begin br = 1; alu = 1; end
      'h05: begin bn = 1; alu = 1; end
      'h08: begin rw = 1; asrc = 1; end
      'h0a: begin rw = 1; asrc = 1; alu = 4; end
      'h0c: begin rw = 1; asrc = 1; alu = 2; immk = 1; end
      'h0d: begin rw = 1; asrc = 1; alu = 3; immk = 1; end
      'h0f: begin rw = 1; asrc = 1; alu = 7; end
      'h02: d.is_j = 1'b1;
      'h03: begin d.is_j = 1'b1; rw = 1; lnk = 1; d.dest = 5'd31; end
      default: d.legal = 1'b0;
    endcase
    if (ins == 32'd0) begin rw = 0; alu = 0; end
    d.ctrl = 12'(rw * 2048 + mr * 1024 + mw * 512 + m2r * 256 + asrc * 128 +
                 br * 64 + bn * 32 + lnk * 16 + alu);
    if (immk == 1) d.imm = 32'(ins[15:0]);
    else if (immk == 2) d.imm = 32'(ins[10:6]);
    else d.imm = {{16{ins[15]}}, ins[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] rand_instr();
    int k = int'($urandom_range(0, 20));
    int rs = int'($urandom_range(0, 7));
    int rt = int'($urandom_range(0, 7));
    int rd = int'($urandom_range(0, 7));
    int sh = int'($urandom_range(0, 31));
    int imm = int'($urandom_range(0, 65535));
    logic [31:0] tgt = $urandom;
    if (k < 8) return enc_r(rs, rt, rd, sh, int'(fn_tab[k]));
    if (k < 17) return enc_i(int'(op_tab[k-8]), rs, rt, imm);
    if (k == 17) return {6'h02, tgt[25:0]};
    if (k == 18) return {6'h03, tgt[25:0]};
    if (k == 19) return enc_i(int'(bad_op[$urandom_range(0, 3)]), rs, rt, imm);
    return enc_r(rs, rt, rd, sh, 'h3f);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.IF_ID = '0;
    bus.wb_RegWrite = 1'b0;
    bus.wb_dest = '0;
    bus.wb_data = '0;
    bus.exmem_RegWrite = 1'b0;
    bus.exmem_dest = '0;
    bus.flush_ID_EX = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.IF_ID = {32'h0000_0104, enc_r(5, 5, 3, 0, 'h20)};
    bus.wb_RegWrite = 1'b1;
    bus.wb_dest = 5'd5;
    bus.wb_data = 32'hdead_beef;
    tick();
    tick();
    compared++;
    if ({bus.ID_EX_PC_plus4, bus.ID_EX_rs_data, bus.ID_EX_rt_data, bus.ID_EX_imm,
         bus.ID_EX_regs, bus.ID_EX_ctrl} !== '0) begin
      mismatched++;
      $display("FAIL reset_idex got pc=%h rs=%h ctrl=%h required all zero",
               bus.ID_EX_PC_plus4, bus.ID_EX_rs_data, bus.ID_EX_ctrl);
    end
    bus.wb_RegWrite = 1'b0;
    rst_n = 1'b1;
    tick();
    compared++;
    if (bus.ID_EX_rs_data !== 32'd0 || bus.ID_EX_ctrl !== 12'h800) begin
      mismatched++;
      $display("FAIL reset_regfile got rs=%h ctrl=%h required rs=0 ctrl=800",
               bus.ID_EX_rs_data, bus.ID_EX_ctrl);
    end
  endtask

  task automatic test_wb_bypass();
    do_reset();
    bus.IF_ID = {32'h0000_0100, enc_r(5, 0, 3, 0, 'h20)};
    bus.wb_RegWrite = 1'b1;
    bus.wb_dest = 5'd5;
    bus.wb_data = 32'h0000_1234;
    tick();
    bus.wb_RegWrite = 1'b0;
    compared++;
    if (bus.ID_EX_rs_data !== 32'h0000_1234 || bus.ID_EX_ctrl !== 12'h800 ||
        bus.ID_EX_regs !== {5'd5, 5'd0, 5'd3} || bus.ID_EX_PC_plus4 !== 32'h100) begin
      mismatched++;
      $display("FAIL wb_bypass got rs=%h ctrl=%h regs=%h pc=%h required 1234/800/%h/100",
               bus.ID_EX_rs_data, bus.ID_EX_ctrl, bus.ID_EX_regs, bus.ID_EX_PC_plus4,
               {5'd5, 5'd0, 5'd3});
    end
    tick();
    compared++;
    if (bus.ID_EX_rs_data !== 32'h0000_1234) begin
      mismatched++;
      $display("FAIL wb_stored got rs=%h required 00001234", bus.ID_EX_rs_data);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.IF_ID = {32'h0000_0008, enc_i('h23, 1, 2, 0)};
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'hd80) begin
      mismatched++;
      $display("FAIL lw_ctrl got %h required d80", bus.ID_EX_ctrl);
    end
    bus.IF_ID = {32'h0000_000c, enc_r(2, 2, 4, 0, 'h20)};
    @(negedge clk);
    compared++;
    if (bus.PC_IF_ID_Write !== 1'b0 || bus.select_JJR !== 2'b00) begin
      mismatched++;
      $display("FAIL load_use_stall got pcw=%b sel=%b required 0/00",
               bus.PC_IF_ID_Write, bus.select_JJR);
    end
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'h000 || bus.ID_EX_regs !== 15'd0) begin
      mismatched++;
      $display("FAIL load_use_bubble got ctrl=%h regs=%h required 0", bus.ID_EX_ctrl, bus.ID_EX_regs);
    end
    @(negedge clk);
    compared++;
    if (bus.PC_IF_ID_Write !== 1'b1) begin
      mismatched++;
      $display("FAIL load_use_release got pcw=%b required 1", bus.PC_IF_ID_Write);
    end
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'h800 || bus.ID_EX_regs !== {5'd2, 5'd2, 5'd4}) begin
      mismatched++;
      $display("FAIL load_use_issue got ctrl=%h regs=%h required 800/%h",
               bus.ID_EX_ctrl, bus.ID_EX_regs, {5'd2, 5'd2, 5'd4});
    end
  endtask

  task automatic test_jump();
    do_reset();
    bus.IF_ID = {32'h8000_0010, 6'h02, 26'h000_0040};
    @(negedge clk);
    compared++;
    if (bus.select_JJR !== 2'b10 || bus.jump_target !== 32'h8000_0100 ||
        bus.PC_IF_ID_Write !== 1'b1 || bus.illegal_inst !== 1'b0) begin
      mismatched++;
      $display("FAIL jump got sel=%b tgt=%h pcw=%b ill=%b required 10/80000100/1/0",
               bus.select_JJR, bus.jump_target, bus.PC_IF_ID_Write, bus.illegal_inst);
    end
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'h000 || bus.ID_EX_PC_plus4 !== 32'h8000_0010) begin
      mismatched++;
      $display("FAIL jump_idex got ctrl=%h pc=%h required 000/80000010",
               bus.ID_EX_ctrl, bus.ID_EX_PC_plus4);
    end
    bus.IF_ID = {32'h0000_0200, 6'h03, 26'h3ff_ffff};
    @(negedge clk);
    compared++;
    if (bus.select_JJR !== 2'b10 || bus.jump_target !== 32'h0fff_fffc) begin
      mismatched++;
      $display("FAIL jal got sel=%b tgt=%h required 10/0ffffffc", bus.select_JJR, bus.jump_target);
    end
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'h810 || bus.ID_EX_regs[4:0] !== 5'd31) begin
      mismatched++;
      $display("FAIL jal_idex got ctrl=%h dest=%0d required 810/31", bus.ID_EX_ctrl, bus.ID_EX_regs[4:0]);
    end
  endtask

  task automatic test_jr_stall();
    int stalls = 0;
    do_reset();
    bus.IF_ID = {32'h0000_0004, enc_i('h08, 0, 7, 'h55)};
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'h880 || bus.ID_EX_imm !== 32'h55) begin
      mismatched++;
      $display("FAIL addi_idex got ctrl=%h imm=%h required 880/55", bus.ID_EX_ctrl, bus.ID_EX_imm);
    end
    bus.IF_ID = {32'h0000_0008, enc_r(7, 0, 0, 0, 'h08)};
    @(negedge clk);
    if (bus.PC_IF_ID_Write === 1'b0 && bus.select_JJR === 2'b00) stalls++;
    tick();
    bus.exmem_RegWrite = 1'b1;
    bus.exmem_dest = 5'd7;
    @(negedge clk);
    if (bus.PC_IF_ID_Write === 1'b0 && bus.select_JJR === 2'b00) stalls++;
    compared++;
    if (stalls !== 2) begin
      mismatched++;
      $display("FAIL jr_stall_cycles got %0d required 2", stalls);
    end
    tick();
    bus.exmem_RegWrite = 1'b0;
    bus.wb_RegWrite = 1'b1;
    bus.wb_dest = 5'd7;
    bus.wb_data = 32'h55;
    @(negedge clk);
    compared++;
    if (bus.PC_IF_ID_Write !== 1'b1 || bus.select_JJR !== 2'b01 || bus.jr_target !== 32'h55) begin
      mismatched++;
      $display("FAIL jr_issue got pcw=%b sel=%b tgt=%h required 1/01/00000055",
               bus.PC_IF_ID_Write, bus.select_JJR, bus.jr_target);
    end
    tick();
    bus.wb_RegWrite = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    bus.IF_ID = {32'h0000_0004, enc_r(2, 3, 1, 0, 'h20)};
    tick();
    bus.IF_ID = {32'h0000_0008, 32'hfc00_0000};
    @(negedge clk);
    compared++;
    if (bus.illegal_inst !== 1'b1 || bus.select_JJR !== 2'b00 || bus.PC_IF_ID_Write !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_op got ill=%b sel=%b pcw=%b required 1/00/1",
               bus.illegal_inst, bus.select_JJR, bus.PC_IF_ID_Write);
    end
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'h000 || bus.ID_EX_regs !== 15'd0) begin
      mismatched++;
      $display("FAIL illegal_bubble got ctrl=%h regs=%h required 0", bus.ID_EX_ctrl, bus.ID_EX_regs);
    end
    bus.IF_ID = {32'h0000_000c, enc_r(1, 2, 3, 0, 'h3f)};
    @(negedge clk);
    compared++;
    if (bus.illegal_inst !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_funct got ill=%b required 1", bus.illegal_inst);
    end
    bus.IF_ID = {32'h0000_0010, enc_r(2, 3, 1, 0, 'h20)};
    tick();
    bus.IF_ID = {32'h0000_0014, 32'hfc00_0000};
    bus.flush_ID_EX = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.illegal_inst !== 1'b0 || bus.PC_IF_ID_Write !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_flush got ill=%b pcw=%b required 0/1", bus.illegal_inst, bus.PC_IF_ID_Write);
    end
    tick();
    bus.flush_ID_EX = 1'b0;
    compared++;
    if (bus.ID_EX_ctrl !== 12'h000) begin
      mismatched++;
      $display("FAIL illegal_flush_bubble got ctrl=%h required 000", bus.ID_EX_ctrl);
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    bus.IF_ID = {32'h0000_0004, enc_i('h23, 1, 2, 0)};
    tick();
    bus.IF_ID = {32'h0000_0008, enc_r(2, 2, 4, 0, 'h20)};
    bus.flush_ID_EX = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.PC_IF_ID_Write !== 1'b1 || bus.select_JJR !== 2'b00) begin
      mismatched++;
      $display("FAIL flush_stall got pcw=%b sel=%b required 1/00", bus.PC_IF_ID_Write, bus.select_JJR);
    end
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'h000 || bus.ID_EX_regs !== 15'd0) begin
      mismatched++;
      $display("FAIL flush_bubble got ctrl=%h regs=%h required 0", bus.ID_EX_ctrl, bus.ID_EX_regs);
    end
    bus.IF_ID = {32'h8000_0010, 6'h02, 26'h000_0040};
    @(negedge clk);
    compared++;
    if (bus.select_JJR !== 2'b00) begin
      mismatched++;
      $display("FAIL flush_jump got sel=%b required 00", bus.select_JJR);
    end
    tick();
    bus.flush_ID_EX = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.IF_ID = {32'h0000_0004, enc_i('h23, 1, 2, 0)};
    tick();
    bus.IF_ID = {32'h0000_0008, enc_r(2, 1, 4, 0, 'h20)};
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'h000 || bus.ID_EX_regs !== 15'd0 || bus.ID_EX_PC_plus4 !== 32'd0) begin
      mismatched++;
      $display("FAIL mid_stall_reset got ctrl=%h regs=%h pc=%h required 0",
               bus.ID_EX_ctrl, bus.ID_EX_regs, bus.ID_EX_PC_plus4);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.PC_IF_ID_Write !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_stall_release got pcw=%b required 1", bus.PC_IF_ID_Write);
    end
    tick();
    compared++;
    if (bus.ID_EX_ctrl !== 12'h800) begin
      mismatched++;
      $display("FAIL mid_stall_issue got ctrl=%h required 800", bus.ID_EX_ctrl);
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] ins = '0, pc = '0, rsv, rtv;
    logic [31:0] e_pc = '0, e_rs = '0, e_rt = '0, e_imm = '0;
    logic [14:0] e_regs = '0;
    logic [11:0] e_ctrl = '0;
    logic        hold = 1'b0, stall, iss, pcw, ill;
    logic [1:0]  sel;
    logic [4:0]  rs, rt, ed;
    dec_t d;
    do_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int c = 0; c < n; c++) begin
      if (!hold) begin
        ins = rand_instr();
        pc = $urandom;
      end
      bus.IF_ID = {pc, ins};
      bus.flush_ID_EX = ($urandom_range(0, 7) == 0);
      bus.wb_RegWrite = 1'($urandom_range(0, 1));
      bus.wb_dest = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      bus.exmem_RegWrite = 1'($urandom_range(0, 1));
      bus.exmem_dest = 5'($urandom_range(0, 7));
      d = ref_decode(ins);
      rs = ins[25:21];
      rt = ins[20:16];
      rsv = ref_read(rs, bus.wb_RegWrite, bus.wb_dest, bus.wb_data);
      rtv = ref_read(rt, bus.wb_RegWrite, bus.wb_dest, bus.wb_data);
      ed = e_regs[4:0];
      stall = (e_ctrl[10] && ed != 0 && (ed == rs || ed == rt)) ||
              (d.is_jr && d.legal && rs != 0 &&
               ((e_ctrl[11] && ed == rs) || (bus.exmem_RegWrite && bus.exmem_dest == rs)));
      iss = !bus.flush_ID_EX && !stall && d.legal;
      pcw = bus.flush_ID_EX || !stall;
      sel = iss ? {d.is_j, d.is_jr} : 2'b00;
      ill = !d.legal && !bus.flush_ID_EX;
      @(negedge clk);
      compared++;
      if (bus.PC_IF_ID_Write !== pcw || bus.select_JJR !== sel || bus.illegal_inst !== ill ||
          bus.jump_target !== {pc[31:28], ins[25:0], 2'b00} || bus.jr_target !== rsv) begin
        mismatched++;
        $display("FAIL rand_comb cyc=%0d ins=%h got pcw=%b sel=%b ill=%b jt=%h jr=%h required %b/%b/%b/%h/%h",
                 c, ins, bus.PC_IF_ID_Write, bus.select_JJR, bus.illegal_inst, bus.jump_target,
                 bus.jr_target, pcw, sel, ill, {pc[31:28], ins[25:0], 2'b00}, rsv);
      end
      if (iss) begin
        e_pc = pc; e_rs = rsv; e_rt = rtv; e_imm = d.imm;
        e_regs = {rs, rt, d.dest}; e_ctrl = d.ctrl;
      end else begin
        e_pc = '0; e_rs = '0; e_rt = '0; e_imm = '0; e_regs = '0; e_ctrl = '0;
      end
      hold = !pcw;
      tick();
      if (bus.wb_RegWrite && bus.wb_dest != 0) m_regs[bus.wb_dest] = bus.wb_data;
      compared++;
      if (bus.ID_EX_PC_plus4 !== e_pc || bus.ID_EX_rs_data !== e_rs || bus.ID_EX_rt_data !== e_rt ||
          bus.ID_EX_imm !== e_imm || bus.ID_EX_regs !== e_regs || bus.ID_EX_ctrl !== e_ctrl) begin
        mismatched++;
        $display("FAIL rand_idex cyc=%0d ins=%h got pc=%h rs=%h rt=%h imm=%h regs=%h ctrl=%h required %h %h %h %h %h %h",
                 c, ins, bus.ID_EX_PC_plus4, bus.ID_EX_rs_data, bus.ID_EX_rt_data, bus.ID_EX_imm,
                 bus.ID_EX_regs, bus.ID_EX_ctrl, e_pc, e_rs, e_rt, e_imm, e_regs, e_ctrl);
      end
    end
    clear_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_wb_bypass();
    test_load_use();
    test_jump();
    test_jr_stall();
    test_illegal();
    test_flush_stall();
    test_reset_mid_stall();
    test_random(600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
